instruction_encoder: RTL and testbench

- Encodes a stream of symbolic instruction requests (operation, register fields, immediate, jump target) into 32-bit MIPS machine words, then writes them sequentially into instruction memory.
- It is the encoding counterpart of the control decoder and supports exactly the same instruction subset: ADD, SUB, SLT, JR, LW, SW, BEQ, BNE, ADDI, XORI, J, JAL.
- It is used by the test and boot infrastructure to load programs before the CPU is released from reset.

---
 rtl/instruction_encoder.sv | 167 ++++++++++++++++
 tb/tb_instruction_encoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Encodes symbolic MIPS instruction requests into 32-bit machine words and
// streams them into instruction memory, one word per cycle, for program loading.
module instruction_encoder #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       count
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpSlt  = 4'd2;
  localparam logic [3:0] OpJr   = 4'd3;
  localparam logic [3:0] OpLw   = 4'd4;
  localparam logic [3:0] OpSw   = 4'd5;
  localparam logic [3:0] OpBeq  = 4'd6;
  localparam logic [3:0] OpBne  = 4'd7;
  localparam logic [3:0] OpAddi = 4'd8;
  localparam logic [3:0] OpXori = 4'd9;
  localparam logic [3:0] OpJ    = 4'd10;
  localparam logic [3:0] OpJal  = 4'd11;
  localparam logic [3:0] OpEnd  = 4'd12;

  localparam logic [15:0] MaxCount = 16'(MAX_WORDS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [15:0]         count_q, count_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [31:0]         addr_ext;
  logic [31:0]         enc_word;
  logic                op_legal;
  logic                op_end;
  logic                at_max;
  logic                unused_addr_bits;

  // Halt word embeds the landing address, so widen it to a fixed 32 bits first.
  assign addr_ext         = 32'(next_addr_q);
  assign unused_addr_bits = ^{addr_ext[31:28], addr_ext[1:0], base_addr[1:0]};
  assign at_max           = (count_q == MaxCount);

  always_comb begin
    enc_word = '0;
    op_legal = 1'b1;
    op_end   = 1'b0;
    case (op_sel)
      OpAdd:  enc_word = {6'h00, rs, rt, rd, 5'h00, 6'h20};
      OpSub:  enc_word = {6'h00, rs, rt, rd, 5'h00, 6'h22};
      OpSlt:  enc_word = {6'h00, rs, rt, rd, 5'h00, 6'h2a};
      OpJr:   enc_word = {6'h00, rs, 15'h0000, 6'h08};
      OpLw:   enc_word = {6'h23, rs, rt, imm};
      OpSw:   enc_word = {6'h2b, rs, rt, imm};
      OpBeq:  enc_word = {6'h04, rs, rt, imm};
      OpBne:  enc_word = {6'h05, rs, rt, imm};
      OpAddi: enc_word = {6'h08, rs, rt, imm};
      OpXori: enc_word = {6'h0e, rs, rt, imm};
      OpJ:    enc_word = {6'h02, target};
      OpJal:  enc_word = {6'h03, target};
      OpEnd: begin
        enc_word = {6'h02, addr_ext[27:2]};
        op_end   = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;
    done_d      = done_q;
    err_d       = err_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          next_addr_d = {base_addr[ADDR_W-1:2], 2'b00};
          count_d     = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
        end
      end
      StRun: begin
        if (in_valid) begin
          if (!op_legal || at_max) begin
            // Terminating request that produces no write.
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            we_d        = 1'b1;
            addr_d      = next_addr_q;
            wdata_d     = enc_word;
            next_addr_d = next_addr_q + ADDR_W'(4);
            count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            if (op_end) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      next_addr_q <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      count_q     <= count_d;
      done_q      <= done_d;
      err_q       <= err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign in_ready   = (state_q == StRun);
  assign busy       = (state_q == StRun);
  assign done       = done_q;
  assign err        = err_q;
  assign count      = count_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: two instances (default and MAX_WORDS=2) share
// stimulus and are checked every cycle against an abstract session model.
module tb_instruction_encoder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  logic        d_ready [2];
  logic        d_we    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic        d_busy  [2];
  logic        d_done  [2];
  logic        d_err   [2];
  logic [15:0] d_count [2];

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  instruction_encoder #(.ADDR_W(32), .MAX_WORDS(256)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(d_ready[0]), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .imem_we(d_we[0]), .imem_addr(d_addr[0]), .imem_wdata(d_wdata[0]),
    .busy(d_busy[0]), .done(d_done[0]), .err(d_err[0]), .count(d_count[0])
  );

  instruction_encoder #(.ADDR_W(32), .MAX_WORDS(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(d_ready[1]), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .imem_we(d_we[1]), .imem_addr(d_addr[1]), .imem_wdata(d_wdata[1]),
    .busy(d_busy[1]), .done(d_done[1]), .err(d_err[1]), .count(d_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Abstract model: session flag, next address, word count, pending write.
  int          max_w   [2] = '{256, 2};
  logic        m_active[2];
  logic        m_done  [2];
  logic        m_err   [2];
  logic [15:0] m_count [2];
  logic [31:0] m_next  [2];
  logic        m_we    [2];
  logic [31:0] m_waddr [2];
  logic [31:0] m_wdata [2];

  function automatic logic [31:0] ref_enc(input int op, input logic [31:0] s, input logic [31:0] t,
                                          input logic [31:0] d, input logic [31:0] im,
                                          input logic [31:0] tg, input logic [31:0] a);
    logic [31:0] r_type;
    logic [31:0] i_base;
    r_type = (s << 21) + (t << 16) + (d << 11);
    i_base = (s << 21) + (t << 16) + im;
    case (op)
      0:  return r_type + 32'h20;
      1:  return r_type + 32'h22;
      2:  return r_type + 32'h2a;
      3:  return (s << 21) + 32'h08;
      4:  return (32'h23 << 26) + i_base;
      5:  return (32'h2b << 26) + i_base;
      6:  return (32'h04 << 26) + i_base;
      7:  return (32'h05 << 26) + i_base;
      8:  return (32'h08 << 26) + i_base;
      9:  return (32'h0e << 26) + i_base;
      10: return (32'h02 << 26) + tg;
      11: return (32'h03 << 26) + tg;
      default: return (32'h02 << 26) + ((a / 4) % (1 << 26));
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_active[i] <= 1'b0; m_done[i] <= 1'b0; m_err[i] <= 1'b0; m_count[i] <= '0;
        m_next[i] <= '0; m_we[i] <= 1'b0; m_waddr[i] <= '0; m_wdata[i] <= '0;
      end else begin
        m_we[i] <= 1'b0;
        if (!m_active[i]) begin
          if (start) begin
            m_active[i] <= 1'b1; m_next[i] <= base_addr & ~32'd3; m_count[i] <= '0;
            m_done[i] <= 1'b0; m_err[i] <= 1'b0;
          end
        end else if (in_valid) begin
          if (int'(op_sel) > 12 || int'(m_count[i]) == max_w[i]) begin
            m_active[i] <= 1'b0; m_done[i] <= 1'b1; m_err[i] <= 1'b1;
          end else begin
            m_we[i]    <= 1'b1;
            m_waddr[i] <= m_next[i];
            m_wdata[i] <= ref_enc(int'(op_sel), 32'(rs), 32'(rt), 32'(rd), 32'(imm),
                                  32'(target), m_next[i]);
            m_next[i]  <= m_next[i] + 32'd4;
            m_count[i] <= (m_count[i] == 16'hFFFF) ? m_count[i] : m_count[i] + 16'd1;
            if (op_sel == 4'd12) begin
              m_active[i] <= 1'b0; m_done[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d]: got %h expected %h at %0t", name, inst, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("in_ready", i, 32'(d_ready[i]), 32'(m_active[i]));
        check("busy", i, 32'(d_busy[i]), 32'(m_active[i]));
        check("done", i, 32'(d_done[i]), 32'(m_done[i]));
        check("err", i, 32'(d_err[i]), 32'(m_err[i]));
        check("count", i, 32'(d_count[i]), 32'(m_count[i]));
        check("imem_we", i, 32'(d_we[i]), 32'(m_we[i]));
        check("imem_addr", i, d_addr[i], m_waddr[i]);
        check("imem_wdata", i, d_wdata[i], m_wdata[i]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                     input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
    in_valid = 1'b1; op_sel = op; rs = s; rt = t; rd = d; imm = im; target = tg;
  endtask

  task automatic begin_session(input logic [31:0] base);
    start = 1'b1; base_addr = base;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    op_sel = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("rst_count", 0, 32'(d_count[0]), 32'd0);
    check("rst_ready", 0, 32'(d_ready[0]), 32'd0);
    check("rst_done", 0, 32'(d_done[0]), 32'd0);
    reset = 1'b0;

    // Single ADD at 0x100.
    begin_session(32'h100);
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    cyc();
    check("add_we", 0, 32'(d_we[0]), 32'd1);
    check("add_addr", 0, d_addr[0], 32'h100);
    check("add_data", 0, d_wdata[0], 32'h00221820);
    check("add_count", 0, 32'(d_count[0]), 32'd1);
    req(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    cyc();
    in_valid = 1'b0;
    cyc();

    // Back-to-back writes from base 0, overflow on the MAX_WORDS=2 instance, then END.
    begin_session(32'h0);
    req(4'd8, 5'd0, 5'd8, 5'd31, 16'h0005, 26'h0);
    cyc();
    check("addi_data", 0, d_wdata[0], 32'h20080005);
    check("addi_addr", 0, d_addr[0], 32'h0);
    req(4'd4, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
    cyc();
    check("lw_data", 0, d_wdata[0], 32'h8FA80004);
    check("lw_addr", 0, d_addr[0], 32'h4);
    req(4'd6, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    cyc();
    check("beq_data", 0, d_wdata[0], 32'h1022FFFF);
    check("beq_addr", 0, d_addr[0], 32'h8);
    check("ovf_we", 1, 32'(d_we[1]), 32'd0);
    check("ovf_done", 1, 32'(d_done[1]), 32'd1);
    check("ovf_err", 1, 32'(d_err[1]), 32'd1);
    check("ovf_count", 1, 32'(d_count[1]), 32'd2);
    req(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    cyc();
    req(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    cyc();
    in_valid = 1'b0;
    check("end_data", 0, d_wdata[0], 32'h08000004);
    check("end_addr", 0, d_addr[0], 32'h10);
    check("end_done", 0, 32'(d_done[0]), 32'd1);
    check("end_err", 0, 32'(d_err[0]), 32'd0);
    check("end_count", 0, 32'(d_count[0]), 32'd5);
    check("end_ready", 0, 32'(d_ready[0]), 32'd0);
    cyc();

    // Illegal op mid-session, then restart.
    begin_session(32'h200);
    req(4'd1, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
    cyc();
    req(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    cyc();
    in_valid = 1'b0;
    check("ill_we", 0, 32'(d_we[0]), 32'd0);
    check("ill_done", 0, 32'(d_done[0]), 32'd1);
    check("ill_err", 0, 32'(d_err[0]), 32'd1);
    check("ill_count", 0, 32'(d_count[0]), 32'd1);
    begin_session(32'h303);
    check("rs_done", 0, 32'(d_done[0]), 32'd0);
    check("rs_err", 0, 32'(d_err[0]), 32'd0);
    check("rs_busy", 0, 32'(d_busy[0]), 32'd1);
    req(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h123_4567);
    cyc();
    check("j_addr", 0, d_addr[0], 32'h300);
    check("j_data", 0, d_wdata[0], 32'h0923_4567);

    // Reset right after a handshake.
    req(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    cyc();
    in_valid = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rr_we", 0, 32'(d_we[0]), 32'd0);
    check("rr_busy", 0, 32'(d_busy[0]), 32'd0);
    check("rr_addr", 0, d_addr[0], 32'h0);
    check("rr_wdata", 0, d_wdata[0], 32'h0);

    // Start during RUN is ignored.
    begin_session(32'h400);
    begin_session(32'h500);
    req(4'd3, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0);
    cyc();
    check("sr_addr", 0, d_addr[0], 32'h400);
    check("jr_data", 0, d_wdata[0], 32'h03E00008);
    in_valid = 1'b0;

    // Randomized traffic, including sessions that wrap the address space.
    repeat (4000) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 19) == 0);
      base_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
      in_valid = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 88)      op_sel = 4'($urandom_range(0, 11));
      else if (r < 96) op_sel = 4'd12;
      else             op_sel = 4'($urandom_range(13, 15));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      imm = 16'($urandom); target = 26'($urandom);
      cyc();
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    cyc();
    chk_en = 1'b0;
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
